// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline hazard logic.
//   FWD_RF / FWD_W / FWD_M : ALU operand forwarding selects (regfile, W, M).
//   REG_AW_DEF             : default register-address width.
//   fwd_sel()              : priority encoder for the Execute forwarding mux;
//                            the M-stage producer is younger, so it wins over W.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        logic [1:0] sel;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md.sv
// -----------------------------------------------------------------------------
// md_scoreboard
// Busy tracker for the multi-cycle multiply/divide unit (HI/LO).
//   clk        in  pipeline clock, rising edge
//   reset      in  asynchronous active-low reset
//   md_start_e in  mult/div instruction in Execute this cycle
//   md_busy    out HI/LO result not yet valid
// After the edge that samples md_start_e the unit stays busy for exactly MD_LAT
// cycles. A new start reloads the counter even while busy.
// -----------------------------------------------------------------------------
module md_scoreboard
    import mips_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    output logic md_busy
);

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

    logic [3:0] md_cnt_d;
    logic [3:0] md_cnt_q;

    // Next count: reload on start, otherwise count down to zero and hold.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_e) begin
            md_cnt_d = MD_LAT_C;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Counter register; reset aborts any in-flight busy window at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (md_cnt_q != 4'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Forwarding, stall and flush generation for the F/D/E/M/W MIPS pipeline, plus
// the mult/div busy scoreboard and a saturating stall-cycle counter.
//   rs_d, rt_d                      in  Decode source registers
//   rs_e, rt_e                      in  Execute source registers
//   writereg_e/m/w, regwrite_e/m/w  in  destination register / write enable
//   memtoreg_e, memtoreg_m          in  load in E / M
//   branch_d, pcsrc_d, jump_d       in  branch, branch taken, jump in Decode
//   md_start_d, md_read_d           in  mult/div, mfhi/mflo in Decode
//   md_start_e                      in  mult/div in Execute
//   forward_ad, forward_bd          out Decode comparator forward from M
//   forward_ae, forward_be          out ALU operand select (FWD_RF/FWD_W/FWD_M)
//   stall_f, stall_d, flush_e       out pipeline stall (bubble into E)
//   flush_d                         out squash IF/ID on taken control transfer
//   md_busy                         out HI/LO not yet valid
//   stall_count                     out saturating count of stalled cycles
// Register 0 is hard-wired zero and never matches a producer.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MD_LAT   = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_AW-1:0]   rs_d,
    input  logic [REG_AW-1:0]   rt_d,
    input  logic [REG_AW-1:0]   rs_e,
    input  logic [REG_AW-1:0]   rt_e,
    input  logic [REG_AW-1:0]   writereg_e,
    input  logic [REG_AW-1:0]   writereg_m,
    input  logic [REG_AW-1:0]   writereg_w,
    input  logic                regwrite_e,
    input  logic                regwrite_m,
    input  logic                regwrite_w,
    input  logic                memtoreg_e,
    input  logic                memtoreg_m,
    input  logic                branch_d,
    input  logic                pcsrc_d,
    input  logic                jump_d,
    input  logic                md_start_d,
    input  logic                md_read_d,
    input  logic                md_start_e,
    output logic                forward_ad,
    output logic                forward_bd,
    output logic [1:0]          forward_ae,
    output logic [1:0]          forward_be,
    output logic                stall_f,
    output logic                stall_d,
    output logic                flush_e,
    output logic                flush_d,
    output logic                md_busy,
    output logic [STALL_CW-1:0] stall_count
);

    localparam logic [REG_AW-1:0]   REG_ZERO  = '0;
    localparam logic [STALL_CW-1:0] CNT_MAX   = {STALL_CW{1'b1}};
    localparam logic [STALL_CW-1:0] CNT_ONE   = STALL_CW'(1);

    logic                md_busy_s;
    logic                lw_stall_s;
    logic                br_stall_s;
    logic                md_stall_s;
    logic                stall_s;
    logic [STALL_CW-1:0] stall_count_d;
    logic [STALL_CW-1:0] stall_count_q;

    md_scoreboard #(
        .MD_LAT (MD_LAT)
    ) u_md_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .md_start_e (md_start_e),
        .md_busy    (md_busy_s)
    );

    // Forwarding selects; still driven while the pipeline is stalled.
    always_comb begin
        forward_ae = fwd_sel((rs_e != REG_ZERO) && regwrite_m && (writereg_m == rs_e),
                             (rs_e != REG_ZERO) && regwrite_w && (writereg_w == rs_e));
        forward_be = fwd_sel((rt_e != REG_ZERO) && regwrite_m && (writereg_m == rt_e),
                             (rt_e != REG_ZERO) && regwrite_w && (writereg_w == rt_e));
        forward_ad = (rs_d != REG_ZERO) && regwrite_m && (writereg_m == rs_d);
        forward_bd = (rt_d != REG_ZERO) && regwrite_m && (writereg_m == rt_d);
    end

    // Stall causes. A branch resolves in Decode, so it must wait for an ALU
    // producer still in E, or for a load still in M (its data is not ready).
    always_comb begin
        lw_stall_s = memtoreg_e && (writereg_e != REG_ZERO) &&
                     ((rs_d == writereg_e) || (rt_d == writereg_e));
        br_stall_s = branch_d &&
                     ((regwrite_e && (writereg_e != REG_ZERO) &&
                       ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
                      (memtoreg_m && (writereg_m != REG_ZERO) &&
                       ((writereg_m == rs_d) || (writereg_m == rt_d))));
        // A start in E has not yet loaded the counter, so it counts as busy.
        md_stall_s = (md_start_d || md_read_d) && (md_busy_s || md_start_e);
        stall_s    = lw_stall_s || br_stall_s || md_stall_s;
    end

    // Pipeline control outputs; a stalled control transfer must not flush.
    always_comb begin
        stall_f = stall_s;
        stall_d = stall_s;
        flush_e = stall_s;
        flush_d = (pcsrc_d || jump_d) && !stall_s;
        md_busy = md_busy_s;
    end

    // Next stall count: one increment per stalled cycle, pinned at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_s && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int MD_LAT = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       branch_d, pcsrc_d, jump_d, md_start_d, md_read_d, md_start_e;

    logic        forward_ad, forward_bd, stall_f, stall_d, flush_e, flush_d, md_busy;
    logic [1:0]  forward_ae, forward_be;
    logic [15:0] stall_count;

    logic        s_ad, s_bd, s_sf, s_sd, s_fe, s_fd, s_busy;
    logic [1:0]  s_ae, s_be;
    logic [2:0]  stall_count3;

    int ncmp  = 0;
    int nfail = 0;

    // behavioural model state
    int m_edge, m_last, m_cnt, m_cnt3;
    bit m_started;

    hazard_scoreboard #(.REG_AW(5), .MD_LAT(MD_LAT), .STALL_CW(16)) u_dut (
        .clk(clk), .reset(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
        .pcsrc_d(pcsrc_d), .jump_d(jump_d), .md_start_d(md_start_d),
        .md_read_d(md_read_d), .md_start_e(md_start_e),
        .forward_ad(forward_ad), .forward_bd(forward_bd), .forward_ae(forward_ae),
        .forward_be(forward_be), .stall_f(stall_f), .stall_d(stall_d),
        .flush_e(flush_e), .flush_d(flush_d), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    hazard_scoreboard #(.REG_AW(5), .MD_LAT(MD_LAT), .STALL_CW(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .branch_d(branch_d),
        .pcsrc_d(pcsrc_d), .jump_d(jump_d), .md_start_d(md_start_d),
        .md_read_d(md_read_d), .md_start_e(md_start_e),
        .forward_ad(s_ad), .forward_bd(s_bd), .forward_ae(s_ae),
        .forward_be(s_be), .stall_f(s_sf), .stall_d(s_sd),
        .flush_e(s_fe), .flush_d(s_fd), .md_busy(s_busy),
        .stall_count(stall_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int m_fwd_e(input logic [4:0] src);
        if (src != 0 && regwrite_m && writereg_m == src) return 2;
        if (src != 0 && regwrite_w && writereg_w == src) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_d(input logic [4:0] src);
        return (src != 0 && regwrite_m && writereg_m == src) ? 1 : 0;
    endfunction

    // Busy while fewer than MD_LAT edges have followed the start edge.
    function automatic bit m_busy();
        return m_started && ((m_edge - m_last) <= MD_LAT);
    endfunction

    function automatic bit m_stall();
        bit lw, br, md;
        lw = memtoreg_e && writereg_e != 0 && (rs_d == writereg_e || rt_d == writereg_e);
        br = branch_d && ((regwrite_e && writereg_e != 0 &&
                           (writereg_e == rs_d || writereg_e == rt_d)) ||
                          (memtoreg_m && writereg_m != 0 &&
                           (writereg_m == rs_d || writereg_m == rt_d)));
        md = (md_start_d || md_read_d) && (m_busy() || md_start_e);
        return lw || br || md;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge    <= 0;
            m_last    <= 0;
            m_started <= 1'b0;
            m_cnt     <= 0;
            m_cnt3    <= 0;
        end else begin
            m_edge <= m_edge + 1;
            if (md_start_e) begin
                m_started <= 1'b1;
                m_last    <= m_edge;
            end
            if (m_stall()) begin
                m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt3 <= (m_cnt3 < 7)     ? m_cnt3 + 1 : m_cnt3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("fwd_ae", 32'(forward_ae), 32'(m_fwd_e(rs_e)));
        chk("fwd_be", 32'(forward_be), 32'(m_fwd_e(rt_e)));
        chk("fwd_ad", 32'(forward_ad), 32'(m_fwd_d(rs_d)));
        chk("fwd_bd", 32'(forward_bd), 32'(m_fwd_d(rt_d)));
        chk("stall_f", 32'(stall_f), 32'(m_stall()));
        chk("stall_d", 32'(stall_d), 32'(m_stall()));
        chk("flush_e", 32'(flush_e), 32'(m_stall()));
        chk("flush_d", 32'(flush_d), 32'((pcsrc_d || jump_d) && !m_stall()));
        chk("md_busy", 32'(md_busy), 32'(m_busy()));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        chk("stall_count3", 32'(stall_count3), 32'(m_cnt3));
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        writereg_e = 0; writereg_m = 0; writereg_w = 0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0; branch_d = 0; pcsrc_d = 0; jump_d = 0;
        md_start_d = 0; md_read_d = 0; md_start_e = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #12;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        step();
        rst_n = 1'b1;

        // forwarding priority
        regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5; rs_e = 5;
        #1 chk("dir_fwd_m", 32'(forward_ae), 32'd2);
        regwrite_m = 0;
        #1 chk("dir_fwd_w", 32'(forward_ae), 32'd1);
        rs_e = 0;
        #1 chk("dir_fwd_rf", 32'(forward_ae), 32'd0);
        step();

        // load-use
        clr(); memtoreg_e = 1; writereg_e = 8; rt_d = 8;
        #1 chk("dir_lw_stall", 32'({stall_f, stall_d, flush_e}), 32'h7);
        chk("dir_lw_cnt0", 32'(stall_count), 32'd0);
        step();
        chk("dir_lw_cnt1", 32'(stall_count), 32'd1);
        writereg_e = 0;
        #1 chk("dir_lw_r0", 32'(stall_f), 32'd0);
        step();
        chk("dir_lw_cnt_hold", 32'(stall_count), 32'd1);

        // branch hazard
        clr(); branch_d = 1; pcsrc_d = 1; regwrite_e = 1; writereg_e = 3; rs_d = 3;
        #1 chk("dir_br_stall", 32'(stall_f), 32'd1);
        chk("dir_br_noflush", 32'(flush_d), 32'd0);
        step();
        clr(); branch_d = 1; pcsrc_d = 1; rs_d = 3; regwrite_m = 1; writereg_m = 3;
        #1 chk("dir_br_go", 32'({stall_f, forward_ad, flush_d}), 32'h3);
        step();
        chk("dir_br_cnt", 32'(stall_count), 32'd2);

        // mult/div busy window
        clr(); md_start_e = 1;
        #1 chk("dir_md_idle", 32'(md_busy), 32'd0);
        step();
        md_start_e = 0; md_read_d = 1;
        for (int i = 1; i <= MD_LAT; i++) begin
            #1 chk("dir_md_busy", 32'({md_busy, stall_f}), 32'h3);
            step();
        end
        #1 chk("dir_md_done", 32'({md_busy, stall_f}), 32'h0);
        chk("dir_md_cnt", 32'(stall_count), 32'd6);
        md_read_d = 0; md_start_d = 1; md_start_e = 1;
        #1 chk("dir_md_b2b", 32'(stall_f), 32'd1);
        step();
        chk("dir_md_b2b_cnt", 32'(stall_count), 32'd7);

        // saturation of the narrow counter
        clr(); memtoreg_e = 1; writereg_e = 8; rt_d = 8;
        repeat (10) step();
        chk("dir_sat3", 32'(stall_count3), 32'd7);
        chk("dir_sat16", 32'(stall_count), 32'd17);

        // reset in the middle of a mult/div
        clr(); repeat (5) step();
        md_start_e = 1; step();
        md_start_e = 0; step(); step();
        chk("dir_pre_rst_busy", 32'(md_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("dir_rst_busy", 32'(md_busy), 32'd0);
        chk("dir_rst_cnt", 32'(stall_count), 32'd0);
        chk("dir_rst_cnt3", 32'(stall_count3), 32'd0);
        step();
        rst_n = 1'b1; md_read_d = 1;
        #1 chk("dir_post_rst", 32'({md_busy, stall_f}), 32'h0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            writereg_e = 5'($urandom_range(0, 3));
            writereg_m = 5'($urandom_range(0, 3));
            writereg_w = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom); regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
            memtoreg_e = ($urandom_range(0, 3) == 0); memtoreg_m = ($urandom_range(0, 3) == 0);
            branch_d = ($urandom_range(0, 3) == 0); pcsrc_d = 1'($urandom);
            jump_d = ($urandom_range(0, 7) == 0);
            md_start_d = ($urandom_range(0, 5) == 0); md_read_d = ($urandom_range(0, 3) == 0);
            md_start_e = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        clr();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard logic embedded in the current 5-stage MIPS controller.
- Computes forwarding selects, stalls and flushes for the F/D/E/M/W pipeline.
- Adds a sequential busy scoreboard for a multi-cycle multiply/divide unit (HI/LO) and a saturating stall-cycle performance counter.
- Instantiated in mips beside controller; all hazard outputs move here.

Parameters:
- REG_AW, 5, register-address width (register 0 hard-wired zero, never forwarded or matched).
- MD_LAT, 4, mult/div latency in cycles; legal range 1..15.
- STALL_CW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_d, rt_d  in  REG_AW  source registers in Decode.
- rs_e, rt_e  in  REG_AW  source registers in Execute.
- writereg_e, writereg_m, writereg_w  in  REG_AW  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  destination write enables.
- memtoreg_e, memtoreg_m  in  1  load in E / M.
- branch_d  in  1  branch in Decode.
- pcsrc_d  in  1  branch taken.
- jump_d  in  1  jump.
- md_start_d  in  1  mult/div in Decode.
- md_read_d  in  1  mfhi/mflo in Decode.
- md_start_e  in  1  mult/div in Execute.
- forward_ad, forward_bd  out  1  Decode comparator forwarding from M.
- forward_ae, forward_be  out  2  ALU operand select: 00 = regfile, 01 = W result, 10 = M ALUOut.
- stall_f, stall_d  out  1  hold PC / IF-ID register.
- flush_e  out  1  clear ID-EX register.
- flush_d  out  1  clear IF-ID register (taken control transfer).
- md_busy  out  1  mult/div result not yet valid.
- stall_count  out  STALL_CW  saturating count of stalled cycles.

Behaviour:
- Forwarding (combinational):
  - forward_ae = 10 if rs_e != 0, regwrite_m and writereg_m == rs_e.
  - Otherwise forward_ae = 01 if rs_e != 0, regwrite_w and writereg_w == rs_e.
  - Otherwise forward_ae = 00. M has priority over W.
  - forward_be is identical using rt_e.
  - forward_ad = (rs_d != 0) & regwrite_m & (writereg_m == rs_d); forward_bd uses rt_d.
- lw_stall = memtoreg_e & ((rs_d == writereg_e) | (rt_d == writereg_e)) & (writereg_e != 0).
- br_stall = branch_d & ((regwrite_e & writereg_e ∈ {rs_d, rt_d}) | (memtoreg_m & writereg_m ∈ {rs_d, rt_d})), with writereg != 0.
- md_stall = (md_start_d | md_read_d) & (md_busy | md_start_e).
- stall = lw_stall | br_stall | md_stall.
- stall_f = stall_d = flush_e = stall.
- flush_d = (pcsrc_d | jump_d) & ~stall. A stalled branch never flushes.
- Mult/div scoreboard:
  - 4-bit counter md_cnt; md_busy = (md_cnt != 0).
  - Rising edge with md_start_e = 1: md_cnt <= MD_LAT.
  - Otherwise, if md_cnt != 0: md_cnt decrements by 1.
  - md_start_e takes priority over decrement.
  - Result: busy for exactly MD_LAT cycles after the edge that sampled the start.
- stall_count:
  - Increments on each edge where stall = 1.
  - Saturates at all-ones and never wraps.
- Reset (reset = 0, asynchronous):
  - md_cnt = 0, stall_count = 0, md_busy = 0.
  - Combinational outputs follow the inputs with state zero.
  - Reset mid-mult/div aborts the busy window immediately.
- Simultaneous events: several stall causes in one cycle count as one stall cycle. Forwarding outputs are still driven during a stall.

Decomposition:
- Shared package mips_pkg holds:
  - forwarding-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - REG_AW default.
- One sub-module, md_scoreboard, containing md_cnt and md_busy. Parameter MD_LAT; ports clk, reset, md_start_e, md_busy.

Test Plan:
- Forwarding: regwrite_m = 1, writereg_m = 5, regwrite_w = 1, writereg_w = 5, rs_e = 5 -> forward_ae = 10. Then regwrite_m = 0 -> 01. Then rs_e = 0 -> 00.
- Load-use: memtoreg_e = 1, writereg_e = 8, rt_d = 8 -> stall_f = stall_d = flush_e = 1 for one cycle, stall_count 0 -> 1. With writereg_e = 0 -> no stall.
- Branch hazard: branch_d = 1, pcsrc_d = 1, regwrite_e = 1, writereg_e = rs_d = 3 -> stall = 1, flush_d = 0. Next cycle (producer in M, not load) -> stall = 0, forward_ad = 1, flush_d = 1.
- Mult/div (MD_LAT = 4): md_start_e pulse at edge 0 -> md_busy high for cycles 1-4. md_read_d held from cycle 1 -> stall cycles 1-4, released cycle 5, stall_count = 4. Back-to-back md_start_d with md_start_e -> stall.
- Saturation with STALL_CW = 3: hold lw_stall for 10 cycles -> stall_count reaches 7 and stays 7.
- Reset mid-operation: assert reset with md_cnt = 2 and stall_count = 5 -> both 0 immediately, without waiting for a clock edge. Release -> md_busy = 0, no stall.
